// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types for the data-memory arbiter
//
// Purpose : port identifiers, the registered read-response tag and a small
//           helper that turns a port id into its one-hot bit position.
// Ports   : none (package).
package dmem_arb_pkg;

   typedef enum logic {
      PORT_CORE   = 1'b0,
      PORT_LOADER = 1'b1
   } port_id_e;

   // Remembers which port owns the read data returning from the memory
   // one cycle after acceptance.
   typedef struct packed {
      logic     valid;
      port_id_e port;
   } rsp_tag_t;

   function automatic logic [1:0] port_onehot(input port_id_e p);
      return (p == PORT_LOADER) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/dmem_arb_grant.sv
// rtl/dmem_arb_grant.sv - one-hot grant decision for the two memory requesters
//
// Purpose : combinational grant. A lone requester is always granted; under
//           contention a starved (saturated) port wins first, port 1 taking
//           precedence if both are starved, otherwise the arbitration policy
//           decides.
// Macro   : DMEM_ARB_RR_EN - defined: round-robin policy (the port not granted
//           last wins); undefined: fixed priority, port 0 wins.
// Ports   : req[1:0]  in   request per port
//           last_port in   port granted most recently
//           sat[1:0]  in   wait counter of the port has reached its limit
//           gnt[1:0]  out  one-hot grant
module dmem_arb_grant
   import dmem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  port_id_e   last_port,
   input  logic [1:0] sat,
   output logic [1:0] gnt
);

   logic [1:0] policy_gnt;

`ifdef DMEM_ARB_RR_EN
   assign policy_gnt = (last_port == PORT_CORE) ? 2'b10 : 2'b01;
`else
   logic unused_last_port;
   assign unused_last_port = last_port;
   assign policy_gnt       = 2'b01;
`endif

   always_comb begin
      gnt = 2'b00;
      if (req == 2'b11) begin
         if (sat[1]) begin
            gnt = 2'b10;
         end else if (sat[0]) begin
            gnt = 2'b01;
         end else begin
            gnt = policy_gnt;
         end
      end else begin
         // Zero or one requester: pass the request straight through.
         gnt = req;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter in front of a synchronous data memory
//
// Purpose : shares one synchronous-read memory between the core MEM stage
//           (port 0) and the loader/debug port (port 1). Grants are issued in
//           the request cycle; read data returns one cycle later, routed by a
//           registered response tag. Per-port wait counters force a starved
//           port through after MAX_WAIT refusals.
// Macro   : DMEM_ARB_RR_EN - defined: round-robin contention policy;
//           undefined: fixed priority with port 0 winning.
// Ports   : i_clk, i_reset             clock, async active-high reset
//           i_req[1:0]                 per-port request
//           i_addr0/1, i_wdata0/1      request address / write data
//           i_wen0/1                   byte enables, all-zero = read
//           o_gnt[1:0]                 one-hot grant (combinational)
//           o_rvalid[1:0], o_rdata     read response
//           o_m_addr/wdata/wen         memory drive
//           i_m_rdata                  memory read data (one cycle latency)
//           o_stall0                   port 0 requesting but not granted
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter  int ADDR_WIDTH = 11,
   parameter  int DATA_WIDTH = 32,
   parameter  int MAX_WAIT   = 8,
   localparam int DATA_BYTES = DATA_WIDTH / 8
)(
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [1:0]            i_req,
   input  logic [ADDR_WIDTH-1:0] i_addr0,
   input  logic [ADDR_WIDTH-1:0] i_addr1,
   input  logic [DATA_WIDTH-1:0] i_wdata0,
   input  logic [DATA_WIDTH-1:0] i_wdata1,
   input  logic [DATA_BYTES-1:0] i_wen0,
   input  logic [DATA_BYTES-1:0] i_wen1,
   output logic [1:0]            o_gnt,
   output logic [1:0]            o_rvalid,
   output logic [DATA_WIDTH-1:0] o_rdata,
   output logic [ADDR_WIDTH-1:0] o_m_addr,
   output logic [DATA_WIDTH-1:0] o_m_wdata,
   output logic [DATA_BYTES-1:0] o_m_wen,
   input  logic [DATA_WIDTH-1:0] i_m_rdata,
   output logic                  o_stall0
);

   localparam int               CNT_W    = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] WAIT_SAT = CNT_W'(MAX_WAIT);

   logic [CNT_W-1:0] wait_cnt [2];
   logic [1:0]       sat;
   logic [1:0]       gnt_raw;
   port_id_e         last_port;
   rsp_tag_t         tag;
   logic             acc_read;

   assign sat = {wait_cnt[1] == WAIT_SAT, wait_cnt[0] == WAIT_SAT};

   dmem_arb_grant u_grant (
      .req       (i_req),
      .last_port (last_port),
      .sat       (sat),
      .gnt       (gnt_raw)
   );

   // Nothing may be accepted while reset is held, so a request presented in
   // the reset cycle can never leave a response behind.
   assign o_gnt    = i_reset ? 2'b00 : gnt_raw;
   assign o_stall0 = i_req[0] & ~o_gnt[0];

   always_comb begin
      o_m_addr  = i_addr0;
      o_m_wdata = i_wdata0;
      o_m_wen   = '0;
      if (o_gnt[1]) begin
         o_m_addr  = i_addr1;
         o_m_wdata = i_wdata1;
         o_m_wen   = i_wen1;
      end else if (o_gnt[0]) begin
         o_m_wen   = i_wen0;
      end
   end

   // o_m_wen already carries the granted port's enables.
   assign acc_read = (|o_gnt) && (o_m_wen == '0);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         tag         <= '{valid: 1'b0, port: PORT_CORE};
         last_port   <= PORT_LOADER;
         wait_cnt[0] <= '0;
         wait_cnt[1] <= '0;
      end else begin
         tag.valid <= acc_read;
         tag.port  <= o_gnt[1] ? PORT_LOADER : PORT_CORE;
         if (|o_gnt) begin
            last_port <= o_gnt[1] ? PORT_LOADER : PORT_CORE;
         end
         for (int p = 0; p < 2; p++) begin
            if (!i_req[p] || o_gnt[p]) begin
               wait_cnt[p] <= '0;
            end else if (wait_cnt[p] != WAIT_SAT) begin
               wait_cnt[p] <= wait_cnt[p] + 1'b1;
            end
         end
      end
   end

   // The tag is cleared asynchronously, so o_rvalid drops the moment reset
   // asserts even if a read was accepted just before.
   assign o_rvalid = tag.valid ? port_onehot(tag.port) : 2'b00;
   assign o_rdata  = i_m_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;

   localparam int AW   = 11;
   localparam int DW   = 32;
   localparam int DB   = 4;
   localparam int MAXW = 8;
   localparam int NW   = 2048;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    i_req;
   logic [AW-1:0] i_addr0, i_addr1;
   logic [DW-1:0] i_wdata0, i_wdata1;
   logic [DB-1:0] i_wen0, i_wen1;
   logic [1:0]    o_gnt, o_rvalid;
   logic [DW-1:0] o_rdata, o_m_wdata, m_rdata;
   logic [AW-1:0] o_m_addr;
   logic [DB-1:0] o_m_wen;
   logic          o_stall0;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MAXW)) dut (
      .i_clk     (clk),
      .i_reset   (rst),
      .i_req     (i_req),
      .i_addr0   (i_addr0),
      .i_addr1   (i_addr1),
      .i_wdata0  (i_wdata0),
      .i_wdata1  (i_wdata1),
      .i_wen0    (i_wen0),
      .i_wen1    (i_wen1),
      .o_gnt     (o_gnt),
      .o_rvalid  (o_rvalid),
      .o_rdata   (o_rdata),
      .o_m_addr  (o_m_addr),
      .o_m_wdata (o_m_wdata),
      .o_m_wen   (o_m_wen),
      .i_m_rdata (m_rdata),
      .o_stall0  (o_stall0)
   );

   function automatic logic [DW-1:0] init_word(input int i);
      if (i == 16) return 32'hDEADBEEF;
      if (i == 48) return 32'hAABBCCDD;
      return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   // Synchronous-read memory attached to the DUT's memory port.
   logic [DW-1:0] mem [NW];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NW; i++) mem[i] <= init_word(i);
      end else begin
         for (int b = 0; b < DB; b++)
            if (o_m_wen[b]) mem[o_m_addr][b*8 +: 8] <= o_m_wdata[b*8 +: 8];
      end
      m_rdata <= mem[o_m_addr];
   end

   // Reference model state.
   logic [DW-1:0] ref_mem [NW];
   int            mw [2];
   int            mlast;
   typedef struct {
      int            due;
      int            port;
      logic [DW-1:0] data;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   int cyc    = 0;
   int n_chk  = 0;
   int n_err  = 0;
   bit mon_on = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset(input bit refill);
      sb.delete();
      mw[0] = 0;
      mw[1] = 0;
      mlast = 1;
      if (refill) for (int i = 0; i < NW; i++) ref_mem[i] = init_word(i);
   endtask

   // Winner under the arbitration rules: lone requester wins, a port refused
   // MAX_WAIT times is forced (port 1 first), otherwise policy.
   function automatic int model_pick(input logic [1:0] req);
      if (req == 2'b00) return -1;
      if (req == 2'b01) return 0;
      if (req == 2'b10) return 1;
      if (mw[1] >= MAXW) return 1;
      if (mw[0] >= MAXW) return 0;
`ifdef DMEM_ARB_RR_EN
      return (mlast == 0) ? 1 : 0;
`else
      return 0;
`endif
   endfunction

   // One request cycle: drive at the falling edge, check the combinational
   // grant, then update the model as the rising edge will.
   task automatic drive(input logic [1:0] req,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [DB-1:0] w0, input logic [DB-1:0] w1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        output int win, output logic [1:0] g, output logic s);
      logic [AW-1:0] a;
      logic [DB-1:0] w;
      logic [DW-1:0] d;
      @(negedge clk);
      i_req    = req;
      i_addr0  = a0;
      i_addr1  = a1;
      i_wen0   = w0;
      i_wen1   = w1;
      i_wdata0 = d0;
      i_wdata1 = d1;
      #1;
      win = model_pick(req);
      g   = o_gnt;
      s   = o_stall0;
      check("gnt", {30'd0, o_gnt}, (win < 0) ? 32'd0 : 32'(1 << win));
      check("stall0", {31'd0, o_stall0}, {31'd0, req[0] && (win != 0)});
      if (win >= 0) begin
         a = (win == 1) ? a1 : a0;
         w = (win == 1) ? w1 : w0;
         d = (win == 1) ? d1 : d0;
         if (w == '0) begin
            sb.push_back('{cyc + 1, win, ref_mem[a]});
         end else begin
            for (int b = 0; b < DB; b++)
               if (w[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
         end
         mlast = win;
      end
      for (int p = 0; p < 2; p++) begin
         if (req[p] && (win != p)) mw[p] = (mw[p] + 1 > MAXW) ? MAXW : mw[p] + 1;
         else                      mw[p] = 0;
      end
   endtask

   // Response monitor: every falling edge either the next expected read
   // response is due or o_rvalid must be low.
   always @(negedge clk) begin
      if (mon_on && !rst) begin
         if (sb.size() > 0 && sb[0].due == cyc) begin
            mon_e = sb.pop_front();
            check("rvalid", {30'd0, o_rvalid}, 32'(1 << mon_e.port));
            check("rdata", o_rdata, mon_e.data);
         end else begin
            check("rvalid_idle", {30'd0, o_rvalid}, 32'd0);
         end
      end
   end

   int         dw;
   logic [1:0] dg;
   logic       ds;

   task automatic idle();
      drive(2'b00, '0, '0, '0, '0, '0, '0, dw, dg, ds);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst   = 1'b1;
      i_req = 2'b00;
      @(negedge clk);
      rst = 1'b0;
      model_reset(1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   int         first_p1;
   logic       stall_at_p1;
   logic [1:0] gseq [4];
   bit         pend [2];
   logic [AW-1:0] pa [2];
   logic [DB-1:0] pw [2];
   logic [DW-1:0] pd [2];

   initial begin
      rst      = 1'b1;
      i_req    = 2'b00;
      i_addr0  = '0;
      i_addr1  = '0;
      i_wen0   = '0;
      i_wen1   = '0;
      i_wdata0 = '0;
      i_wdata1 = '0;
      model_reset(1);

      // Requests during reset: no grant, no response afterwards.
      repeat (2) @(negedge clk);
      i_req = 2'b11;
      #1;
      check("rst_gnt", {30'd0, o_gnt}, 32'd0);
      check("rst_rvalid", {30'd0, o_rvalid}, 32'd0);
      check("rst_stall0", {31'd0, o_stall0}, 32'd1);
      @(negedge clk);
      check("rst_rvalid_after", {30'd0, o_rvalid}, 32'd0);
      rst   = 1'b0;
      i_req = 2'b00;
      model_reset(1);
      mon_on = 1;

      // Single read from port 0 of the preset word.
      drive(2'b01, 11'h010, '0, 4'h0, '0, '0, '0, dw, dg, ds);
      check("single_gnt", {30'd0, dg}, 32'd1);
      idle();

      // Port 1 write then port 0 read-back.
      drive(2'b10, '0, 11'h020, '0, 4'hF, '0, 32'h12345678, dw, dg, ds);
      drive(2'b01, 11'h020, '0, 4'h0, '0, '0, '0, dw, dg, ds);
      idle();

      // Partial byte write then read-back.
      drive(2'b01, 11'h030, '0, 4'b0001, '0, 32'h000000EE, '0, dw, dg, ds);
      drive(2'b01, 11'h030, '0, 4'h0, '0, '0, '0, dw, dg, ds);
      idle();
      idle();

      // Continuous contention from a fresh reset.
      do_reset();
      first_p1    = 0;
      stall_at_p1 = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         drive(2'b11, 11'(i), 11'(100 + i), '0, '0, '0, '0, dw, dg, ds);
         if (i <= 4) gseq[i-1] = dg;
         if (dg == 2'b10 && first_p1 == 0) begin
            first_p1    = i;
            stall_at_p1 = ds;
         end
      end
`ifndef DMEM_ARB_RR_EN
      check("p1_first_grant_cycle", 32'(first_p1), 32'd9);
      check("stall0_on_p1_grant", {31'd0, stall_at_p1}, 32'd1);
`else
      check("rr_seq0", {30'd0, gseq[0]}, 32'd1);
      check("rr_seq1", {30'd0, gseq[1]}, 32'd2);
      check("rr_seq2", {30'd0, gseq[2]}, 32'd1);
      check("rr_seq3", {30'd0, gseq[3]}, 32'd2);
`endif
      idle();
      idle();

      // Accepted read killed by an asynchronous reset pulse mid-cycle.
      drive(2'b11, 11'h005, 11'h006, '0, '0, '0, '0, dw, dg, ds);
      drive(2'b11, 11'h005, 11'h006, '0, '0, '0, '0, dw, dg, ds);
      drive(2'b01, 11'h005, '0, '0, '0, '0, '0, dw, dg, ds);
      @(posedge clk);
      #2;
      rst   = 1'b1;
      i_req = 2'b00;
      #1;
      check("async_rst_rvalid", {30'd0, o_rvalid}, 32'd0);
      check("async_rst_gnt", {30'd0, o_gnt}, 32'd0);
      model_reset(0);
      #1;
      rst = 1'b0;
      // Counters must restart from zero: the model expects a full wait.
      for (int i = 0; i < 11; i++)
         drive(2'b11, 11'(i), 11'(200 + i), '0, '0, '0, '0, dw, dg, ds);
      idle();

      // Randomized traffic; each requester holds its request until granted.
      pend[0] = 0;
      pend[1] = 0;
      for (int c = 0; c < 400; c++) begin
         for (int p = 0; p < 2; p++) begin
            if (!pend[p] && $urandom_range(0, 99) < 60) begin
               pend[p] = 1;
               pa[p]   = 11'($urandom_range(0, 63));
               pw[p]   = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
               pd[p]   = $urandom;
            end
         end
         drive({pend[1], pend[0]}, pa[0], pa[1], pw[0], pw[1], pd[0], pd[1], dw, dg, ds);
         if (dw >= 0) pend[dw] = 0;
      end
      idle();
      idle();
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
